// File: rtl/mul_issue_stage.sv
// mul_issue_stage
//   Issue/writeback wrapper around an external multi-cycle multiplier.
//   Accepts one multiply operation at a time, registers its operands,
//   pulses a request to the multiplier, waits for the result and presents
//   it on a valid/ready writeback port. func3 values with bit 2 set are
//   not multiplies; they complete immediately with a zero result.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   kill_i                       pipeline flush, aborts any in-flight op
//   valid_i / ready_o            operation handshake from issue
//   func3_i, int_32_i            operation select, word (MULW) flag
//   src1_i, src2_i, rd_i         operands and destination tag
//   mul_request_o, mul_kill_o    one-cycle request / abort to multiplier
//   mul_func3_o .. mul_src2_o    registered operation held to multiplier
//   mul_done_i, mul_result_i     multiplier completion and result
//   wb_valid_o / wb_ready_i      writeback handshake
//   wb_data_o, wb_rd_o           writeback data (zero when not valid), tag
module mul_issue_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       func3_i,
    input  logic             int_32_i,
    input  logic [63:0]      src1_i,
    input  logic [63:0]      src2_i,
    input  logic [TAG_W-1:0] rd_i,
    output logic             mul_request_o,
    output logic             mul_kill_o,
    output logic [2:0]       mul_func3_o,
    output logic             mul_int_32_o,
    output logic [63:0]      mul_src1_o,
    output logic [63:0]      mul_src2_o,
    input  logic             mul_done_i,
    input  logic [63:0]      mul_result_i,
    output logic             wb_valid_o,
    output logic [63:0]      wb_data_o,
    output logic [TAG_W-1:0] wb_rd_o,
    input  logic             wb_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               capture;
    logic [2:0]         func3_q;
    logic               int_32_q;
    logic [63:0]        src1_q;
    logic [63:0]        src2_q;
    logic [TAG_W-1:0]   rd_q;
    logic [63:0]        data_q;

    always_comb begin
        state_d       = state_q;
        ready_o       = 1'b0;
        mul_request_o = 1'b0;
        mul_kill_o    = 1'b0;
        wb_valid_o    = 1'b0;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            ISSUE: begin
                mul_request_o = 1'b1;
                if (kill_i) begin
                    mul_kill_o = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Kill has priority: a result arriving in the same cycle is dropped.
                if (kill_i) begin
                    mul_kill_o = 1'b1;
                    state_d    = IDLE;
                end else if (mul_done_i) begin
                    capture    = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                wb_valid_o = 1'b1;
                ready_o    = wb_ready_i;
                if (kill_i || wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new op accepted on the writeback transfer cycle overrides the
        // return to IDLE, giving back-to-back issue.
        accept = valid_i & ready_o & ~kill_i;
        if (accept) begin
            state_d = func3_i[2] ? RESP : ISSUE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            func3_q  <= '0;
            int_32_q <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                func3_q  <= func3_i;
                int_32_q <= int_32_i;
                src1_q   <= src1_i;
                src2_q   <= src2_i;
                rd_q     <= rd_i;
                // Non-multiply ops go straight to RESP and report zero.
                data_q   <= '0;
            end else if (capture) begin
                data_q <= int_32_q ? {{32{mul_result_i[31]}}, mul_result_i[31:0]}
                                   : mul_result_i;
            end
        end
    end

    assign mul_func3_o  = func3_q;
    assign mul_int_32_o = int_32_q;
    assign mul_src1_o   = src1_q;
    assign mul_src2_o   = src2_q;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_valid_o ? data_q : '0;

endmodule

// File: doc/mul_issue_stage.md
MUL_ISSUE_STAGE -- requirements
Module: mul_issue_stage

Interface
REQ-001 Parameter: TAG_W, default 5, destination-register tag width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 kill_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-005 valid_i  input  1  issue stage presents a multiply operation.
REQ-006 ready_o  output  1  stage accepts an operation this cycle.
REQ-007 func3_i  input  3  operation select: 000 MUL/MULW, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-008 int_32_i  input  1  word (MULW) operation; legal only with func3_i=000.
REQ-009 src1_i, src2_i  input  64 each  operands rs1, rs2.
REQ-010 rd_i  input  TAG_W  destination tag.
REQ-011 mul_request_o  output  1  one-cycle request to multiplier.
REQ-012 mul_kill_o  output  1  abort to multiplier.
REQ-013 mul_func3_o  output  3; mul_int_32_o  output  1; mul_src1_o, mul_src2_o  output  64 each; registered operation held to multiplier.
REQ-014 mul_done_i  input  1  multiplier result valid this cycle.
REQ-015 mul_result_i  input  64  multiplier result, valid only with mul_done_i.
REQ-016 wb_valid_o  output  1; wb_data_o  output  64; wb_rd_o  output  TAG_W; writeback handshake with wb_ready_i  input  1.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-018 Accept (valid_i & ready_o & ~kill_i) SHALL register func3, int_32, src1, src2, rd and move to ISSUE (func3_i[2]=0) or RESP with data 0 (func3_i[2]=1, multiplier not engaged).
REQ-019 ready_o SHALL be 1 in IDLE, and in RESP when wb_ready_i=1; 0 otherwise.
REQ-020 In ISSUE, mul_request_o SHALL be 1 for exactly one cycle, then state WAIT.
REQ-021 mul_func3_o, mul_int_32_o, mul_src1_o, mul_src2_o SHALL hold registered values unchanged from ISSUE through the cycle mul_done_i is sampled.
REQ-022 In WAIT, mul_done_i=1 SHALL capture the result and move to RESP; WAIT has no timeout; nominal accept-to-wb_valid_o latency is 3 cycles.
REQ-023 mul_done_i outside WAIT SHALL be ignored.
REQ-024 Captured data: int_32=1 -> {32 copies of mul_result_i[31], mul_result_i[31:0]}; else mul_result_i unmodified.
REQ-025 In RESP, wb_valid_o=1 with stable wb_data_o, wb_rd_o until wb_ready_i=1; the transfer cycle returns to IDLE, or to ISSUE/RESP if a new op is accepted the same cycle (back-to-back).
REQ-026 kill_i in ISSUE or WAIT SHALL assert mul_kill_o for that cycle and return to IDLE next cycle; a same-cycle mul_done_i is discarded.
REQ-027 kill_i in RESP SHALL drop wb_valid_o next cycle and return to IDLE; kill_i with valid_i SHALL NOT accept; kill_i in IDLE has no effect.
REQ-028 mul_kill_o SHALL be 0 in IDLE and RESP.
REQ-029 wb_data_o SHALL be 0 whenever wb_valid_o=0.

Reset
REQ-030 rst_i asserted SHALL immediately force IDLE; mul_request_o, mul_kill_o, wb_valid_o = 0; all operand, tag and result registers = 0.
REQ-031 Reset mid-operation SHALL abandon the operation with no writeback; first accept possible in first cycle after rst_i deasserts.

Verification
REQ-032 MUL: src1=0xFFFFFFFFFFFFFFFE, src2=3, rd=7, model returns 0xFFFFFFFFFFFFFFFA -> one mul_request_o pulse at T+1, wb_valid_o at T+3, wb_data_o=0xFFFFFFFFFFFFFFFA, wb_rd_o=7.
REQ-033 MULW: int_32=1, model result 0x00000000_80000000 -> wb_data_o=0xFFFFFFFF80000000.
REQ-034 Backpressure: wb_ready_i=0 for 5 cycles in RESP -> wb_valid_o, wb_data_o stable, ready_o=0; then wb_ready_i=1 with new valid_i -> accepted same cycle, next mul_request_o one cycle later.
REQ-035 kill_i in WAIT -> mul_kill_o=1 that cycle, IDLE next, no wb_valid_o even if mul_done_i arrives next cycle.
REQ-036 func3_i=100 -> no mul_request_o, wb_valid_o next cycle with wb_data_o=0.
REQ-037 rst_i pulsed during WAIT -> outputs zero immediately, later mul_done_i ignored, no writeback.
